// File: rtl/rs_pkg.sv
// Shared types and constants for the RS(255,239) codeword framer.
// Holds the byte type, framer state encoding and a message-length clamp helper.
package rs_pkg;

    localparam int RS_NPAR    = 16;
    localparam int RS_MSG_MAX = 239;

    typedef logic [7:0] rs_byte_t;

    typedef enum logic [1:0] {
        ST_DATA,
        ST_LOAD,
        ST_PARITY
    } rs_state_t;

    function automatic rs_byte_t rs_clamp_len(input rs_byte_t req, input rs_byte_t max_len);
        return (req == 8'd0 || req > max_len) ? max_len : req;
    endfunction

endpackage

// File: rtl/rs_codeword_framer_if.sv
// Upstream message stream and downstream codeword stream of the framer.
// slave: framer side; master: the environment that feeds and drains it.
interface rs_codeword_framer_if;
    import rs_pkg::*;

    rs_byte_t s_data;
    logic     s_valid;
    logic     s_ready;
    rs_byte_t m_data;
    logic     m_valid;
    logic     m_ready;
    logic     m_last;
    logic     m_is_parity;

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last, m_is_parity
    );

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last, m_is_parity
    );

endinterface

// File: rtl/rs_par_shift.sv
// Parity buffer: parallel-loads the 16 encoder remainder bytes, shifts one out per advance.
// Latency: head valid the cycle after load; each shift exposes the next byte one cycle later.
// Backpressure: holds contents whenever shift is low.
module rs_par_shift
    import rs_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic                       shift,
    input  logic [RS_NPAR-1:0][7:0]    par_in,
    output rs_byte_t                   head
);

    logic [RS_NPAR-1:0][7:0] sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= par_in;
        end else if (shift) begin
            sreg <= {sreg[RS_NPAR-2:0], 8'h00};
        end
    end

    // Top entry is par15, so the highest-order remainder byte leaves first.
    assign head = sreg[RS_NPAR-1];

endmodule

// File: rtl/rs_codeword_framer.sv
// Frames MSG_LEN message bytes plus 16 RS parity bytes; RS_SHORT_CW_EN adds a per-codeword msg_len.
// Latency: 1 cycle s->m; one LOAD cycle between last data byte and first parity byte.
// Backpressure: single output register; s_ready only in DATA when that register is free.
module rs_codeword_framer
    import rs_pkg::*;
#(
    parameter int MSG_LEN = 239,
    parameter int NPAR    = 16
) (
    input  logic                 clkin,
    input  logic                 rst,
    rs_codeword_framer_if.slave  bus,
`ifdef RS_SHORT_CW_EN
    input  rs_byte_t             msg_len,
`endif
    output rs_byte_t             enc_datain,
    output logic                 enc_valid,
    output logic                 enc_clr,
    input  rs_byte_t             par0,  par1,  par2,  par3,
    input  rs_byte_t             par4,  par5,  par6,  par7,
    input  rs_byte_t             par8,  par9,  par10, par11,
    input  rs_byte_t             par12, par13, par14, par15
);

    localparam rs_byte_t LEN_MAX  = rs_byte_t'(MSG_LEN);
    localparam rs_byte_t PAR_LAST = rs_byte_t'(NPAR - 1);

    rs_state_t state, state_nxt;
    rs_byte_t  count, count_inc, len_now, par_head;
    logic      slot_free, accept, buf_load, par_adv;
    logic [RS_NPAR-1:0][7:0] par_vec;

    assign par_vec = {par15, par14, par13, par12, par11, par10, par9, par8,
                      par7,  par6,  par5,  par4,  par3,  par2,  par1, par0};

`ifdef RS_SHORT_CW_EN
    rs_byte_t cw_len;

    // Length is latched with byte 1; byte 1 itself must already see the new value.
    assign len_now = (count == 8'd0) ? rs_clamp_len(msg_len, LEN_MAX) : cw_len;

    always_ff @(posedge clkin) begin
        if (rst) begin
            cw_len <= LEN_MAX;
        end else if (accept && count == 8'd0) begin
            cw_len <= rs_clamp_len(msg_len, LEN_MAX);
        end
    end
`else
    assign len_now = LEN_MAX;
`endif

    assign slot_free   = !bus.m_valid || bus.m_ready;
    assign bus.s_ready = (state == ST_DATA) && slot_free && !rst;
    assign accept      = bus.s_valid && bus.s_ready;
    assign enc_valid   = accept;
    assign enc_datain  = bus.s_data;
    assign count_inc   = count + 8'd1;

    always_ff @(posedge clkin) begin
        if (rst) begin
            state <= ST_DATA;
        end else begin
            state <= state_nxt;
        end
    end

    // State returns to DATA once the final parity byte is loaded, so the next
    // codeword's first byte can be taken on the same cycle m_last is consumed.
    always_comb begin
        state_nxt = state;
        buf_load  = 1'b0;
        par_adv   = 1'b0;
        enc_clr   = rst;
        case (state)
            ST_DATA: begin
                if (accept && count_inc == len_now) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                buf_load  = 1'b1;
                enc_clr   = 1'b1;
                state_nxt = ST_PARITY;
            end
            ST_PARITY: begin
                if (slot_free) begin
                    par_adv = 1'b1;
                    if (count == PAR_LAST) begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            default: state_nxt = ST_DATA;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            count           <= 8'd0;
            bus.m_data      <= 8'd0;
            bus.m_valid     <= 1'b0;
            bus.m_last      <= 1'b0;
            bus.m_is_parity <= 1'b0;
        end else begin
            case (state)
                ST_DATA: begin
                    if (accept) begin
                        bus.m_data      <= bus.s_data;
                        bus.m_valid     <= 1'b1;
                        bus.m_is_parity <= 1'b0;
                        bus.m_last      <= 1'b0;
                        count           <= (count_inc == len_now) ? 8'd0 : count_inc;
                    end else if (bus.m_ready) begin
                        bus.m_valid <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (bus.m_ready) begin
                        bus.m_valid <= 1'b0;
                    end
                end
                ST_PARITY: begin
                    if (par_adv) begin
                        bus.m_data      <= par_head;
                        bus.m_valid     <= 1'b1;
                        bus.m_is_parity <= 1'b1;
                        bus.m_last      <= (count == PAR_LAST);
                        count           <= (count == PAR_LAST) ? 8'd0 : count_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    rs_par_shift u_par_shift (
        .clk    (clkin),
        .rst    (rst),
        .load   (buf_load),
        .shift  (par_adv),
        .par_in (par_vec),
        .head   (par_head)
    );

endmodule

// File: doc/rs_codeword_framer.md
RS_CODEWORD_FRAMER -- requirements
Module: rs_codeword_framer

Interface
REQ-001 SHALL have parameter MSG_LEN, default 239, giving the number of message bytes per codeword (legal range 1..239).
REQ-002 SHALL have parameter NPAR, default 16, giving the number of parity bytes per codeword; it is fixed at 16 to match the encoder.
REQ-003 SHALL have port clkin, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports s_data, input, 8 bits, and s_valid, input, 1 bit: the upstream message byte stream.
REQ-006 SHALL have port s_ready, output, 1 bit: asserted when the block accepts a message byte this cycle.
REQ-007 SHALL have ports m_data, output, 8 bits, and m_valid, output, 1 bit: the downstream codeword byte stream.
REQ-008 SHALL have port m_ready, input, 1 bit: downstream accept.
REQ-009 SHALL have ports m_last, output, 1 bit (final codeword byte), and m_is_parity, output, 1 bit (current byte is parity).
REQ-010 SHALL have ports enc_datain, output, 8 bits, and enc_valid, output, 1 bit: drive the encoder's datain and valid.
REQ-011 SHALL have port enc_clr, output, 1 bit: drives the encoder's rst.
REQ-012 SHALL have ports par0..par15, input, 8 bits each: the encoder's q0..q15 remainder registers.

Function
REQ-013 SHALL implement states DATA, LOAD and PARITY, with the state held in a register.
REQ-014 SHALL drive s_ready = (state==DATA) && (!m_valid || m_ready); a byte is accepted when s_valid && s_ready.
REQ-015 SHALL drive enc_valid = accepted and enc_datain = s_data, both combinational, so the encoder absorbs the byte on the same edge.
REQ-016 On an accepted byte, SHALL register m_data<=s_data, m_valid<=1, m_is_parity<=0, m_last<=0, and increment an 8-bit byte count; the latency from s to m is 1 cycle.
REQ-017 SHALL return m_valid to 0 on an m_ready handshake when no new byte loads that cycle.
REQ-018 When the byte accepted in DATA is byte number MSG_LEN, SHALL clear the count and move to LOAD.
REQ-019 The LOAD state SHALL last exactly 1 cycle, with s_ready=0.
REQ-020 In LOAD, SHALL capture par15..par0 into a 16-byte buffer, assert enc_clr for that cycle, and move to PARITY.
REQ-021 In PARITY, SHALL load the next buffer byte into m_data whenever (!m_valid || m_ready), with m_is_parity=1; bytes go out in order par15 first, par0 last.
REQ-022 SHALL set m_last=1 on the 16th parity byte; when that byte's handshake completes, SHALL return to DATA.
REQ-023 SHALL hold m_data, m_valid, m_last and m_is_parity stable while m_valid && !m_ready (no drop, no duplicate).
REQ-024 A byte from the next codeword SHALL be accepted in the same cycle the m_last handshake completes, giving zero bubble between codewords.
REQ-025 The last data byte SHALL remain valid on m through LOAD if it has not yet been consumed; the first parity byte loads only after it is consumed.
REQ-026 SHALL ignore s_valid outside DATA; upstream is back-pressured via s_ready.

Reset
REQ-027 While rst is high, SHALL set state=DATA, count=0, m_valid=0, m_last=0, m_is_parity=0, m_data=0, and clear the buffer.
REQ-028 SHALL drive enc_clr = rst || (state==LOAD), so a reset in mid-codeword also clears the encoder.
REQ-029 While rst is high, SHALL drive s_ready=0 and enc_valid=0.

Configuration
REQ-030 Macro RS_SHORT_CW_EN defined: SHALL add input msg_len, 8 bits, sampled when byte 1 of a codeword is accepted; that value sets the codeword length.
REQ-031 With RS_SHORT_CW_EN, a msg_len of 0 or greater than MSG_LEN SHALL clamp to MSG_LEN, and a change to msg_len in mid-codeword SHALL be ignored.
REQ-032 Macro RS_SHORT_CW_EN undefined: SHALL have no msg_len port and SHALL use a fixed length of MSG_LEN.

Structure
REQ-033 Package rs_pkg SHALL hold RS_NPAR=16, RS_MSG_MAX=239, the byte typedef, and the framer state enum.
REQ-034 Sub-module rs_par_shift SHALL be a 16x8 register with parallel load and a shift-out-one-byte-per-advance operation.

Verification
REQ-035 Bench SHALL cover: MSG_LEN=4, stream bytes 01,02,03,04 with m_ready=1 -> m carries 01..04 (m_is_parity=0), then 16 parity bytes matching the reference remainder, par15 first, m_last only on byte 20.
REQ-036 Bench SHALL cover: an all-zero message of 239 bytes -> all 16 parity bytes = 00, with enc_clr pulsed once in LOAD.
REQ-037 Bench SHALL cover: m_ready toggled 0,1,0,1 -> outputs held during stall, no byte lost or repeated, and s_ready=0 while m_valid && !m_ready.
REQ-038 Bench SHALL cover: rst asserted after byte 2 of 4, then a fresh codeword -> parity is identical to a clean run, with count=0 and m_valid=0 on the cycle after rst.
REQ-039 Bench SHALL cover: two back-to-back codewords with s_valid held high -> the first byte of codeword 2 is accepted on the m_last handshake cycle.
REQ-040 Bench SHALL cover, with RS_SHORT_CW_EN: msg_len=0 -> 239 data bytes; msg_len=3 -> 3 data bytes plus 16 parity bytes.
